fft_frame_streamer: RTL and testbench

Synthesizable, parametrised frame source and output tracker for the FFT core. It holds one N-point complex frame in a register buffer and streams it as back-to-back or gapped frames on `enable_in`/`in_re`/`in_im`. It then tracks the core's `enable_out` stream, producing bin index, frame-done and frame-error indications. It replaces fixed single-frame testbench stimulus, so multi-frame and on-chip FFT runs use one block.

---
 rtl/fft_pkg.sv | 24 ++
 rtl/fft_out_tracker.sv | 56 +++++
 rtl/fft_frame_streamer.sv | 170 +++++++++++++++++
 tb/tb_fft_frame_streamer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types for the FFT frame streamer: FSM states, sample layout
// and the address-width helper used to size buffer and bin indices.
`timescale 1ns/1ps
package fft_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } fft_state_e;

    localparam int FFT_WIDTH_DEF = 8;

    // Default-width sample; the streamer re-declares it at its own WIDTH.
    typedef struct packed {
        logic [FFT_WIDTH_DEF-1:0] re;
        logic [FFT_WIDTH_DEF-1:0] im;
    } fft_sample_t;

    function automatic int fft_aw(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/fft_out_tracker.sv
// Follows the FFT core's output-valid stream: bin index, frame-done and
// truncation pulses, and a saturating completed-frame counter.
`timescale 1ns/1ps
module fft_out_tracker
    import fft_pkg::*;
#(
    parameter  int N  = 64,
    localparam int AW = fft_aw(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_enable_out,
    output logic [AW-1:0] o_bin,
    output logic          o_frame_done,
    output logic          o_frame_err,
    output logic [15:0]   o_frames
);

    logic [AW-1:0] r_cnt;
    logic          r_done;
    logic          r_err;
    logic [15:0]   r_frames;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_frames <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (i_enable_out) begin
                if (r_cnt == AW'(N - 1)) begin
                    r_cnt  <= '0;
                    r_done <= 1'b1;
                    if (r_frames != 16'hFFFF) begin
                        r_frames <= r_frames + 16'd1;
                    end
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else if (r_cnt != '0) begin
                // valid dropped mid-frame: the frame was truncated
                r_cnt <= '0;
                r_err <= 1'b1;
            end
        end
    end

    assign o_bin        = r_cnt;
    assign o_frame_done = r_done;
    assign o_frame_err  = r_err;
    assign o_frames     = r_frames;

endmodule

// File: rtl/fft_frame_streamer.sv
// Replays one buffered N-point complex frame into the FFT core as single,
// multiple or continuous frames, and tracks the core's output stream.
`timescale 1ns/1ps
module fft_frame_streamer
    import fft_pkg::*;
#(
    parameter  int N           = 64,
    parameter  int WIDTH       = 8,
    parameter  int FRAME_CNT_W = 8,
    parameter  int GAP_W       = 8,
    localparam int AW          = fft_aw(N)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [2*WIDTH-1:0]     wr_data,
    input  logic                   start,
    input  logic                   stop,
    input  logic [FRAME_CNT_W-1:0] num_frames,
    input  logic [GAP_W-1:0]       gap,
    output logic                   busy,
    output logic                   enable_in,
    output logic [WIDTH-1:0]       in_re,
    output logic [WIDTH-1:0]       in_im,
    input  logic                   enable_out,
    output logic [AW-1:0]          out_bin,
    output logic                   out_frame_done,
    output logic                   out_frame_err,
    output logic [15:0]            out_frames
);

    typedef struct packed {
        logic [WIDTH-1:0] re;
        logic [WIDTH-1:0] im;
    } sample_t;

    sample_t                r_buf [N];
    fft_state_e             r_state;
    fft_state_e             w_state_nxt;
    logic [AW-1:0]          r_addr;
    logic [AW-1:0]          w_addr_nxt;
    logic [FRAME_CNT_W-1:0] r_num;
    logic [FRAME_CNT_W-1:0] w_num_nxt;
    logic [FRAME_CNT_W-1:0] r_sent;
    logic [FRAME_CNT_W-1:0] w_sent_nxt;
    logic [FRAME_CNT_W-1:0] w_sent_inc;
    logic [GAP_W-1:0]       r_gap;
    logic [GAP_W-1:0]       w_gap_nxt;
    logic [GAP_W-1:0]       r_gap_cnt;
    logic [GAP_W-1:0]       w_gap_cnt_nxt;
    logic                   r_stop_pend;
    logic                   w_stop_pend_nxt;
    logic                   w_pend;
    logic                   w_last;
    logic                   w_emit;
    sample_t                w_rd;

    // Not reset; a same-cycle read sees the pre-write contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_buf[wr_addr] <= sample_t'(wr_data);
        end
    end

    assign w_pend     = r_stop_pend | stop;
    assign w_last     = (r_addr == AW'(N - 1));
    assign w_sent_inc = r_sent + 1'b1;
    assign w_rd       = r_buf[w_addr_nxt];

    always_comb begin
        w_state_nxt     = r_state;
        w_addr_nxt      = r_addr;
        w_num_nxt       = r_num;
        w_gap_nxt       = r_gap;
        w_sent_nxt      = r_sent;
        w_gap_cnt_nxt   = r_gap_cnt;
        w_stop_pend_nxt = r_stop_pend;
        w_emit          = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt     = PLAY;
                    w_addr_nxt      = '0;
                    w_num_nxt       = num_frames;
                    w_gap_nxt       = gap;
                    w_sent_nxt      = '0;
                    w_stop_pend_nxt = 1'b0;
                    w_emit          = 1'b1;
                end
            end
            PLAY: begin
                w_stop_pend_nxt = w_pend;
                if (!w_last) begin
                    w_addr_nxt = r_addr + 1'b1;
                    w_emit     = 1'b1;
                end else begin
                    w_sent_nxt = w_sent_inc;
                    w_addr_nxt = '0;
                    if (w_pend || (r_num != '0 && w_sent_inc == r_num)) begin
                        w_state_nxt = IDLE;
                    end else if (r_gap != '0) begin
                        w_state_nxt   = GAP;
                        w_gap_cnt_nxt = r_gap;
                    end else begin
                        w_emit = 1'b1;
                    end
                end
            end
            GAP: begin
                w_stop_pend_nxt = w_pend;
                if (r_gap_cnt <= GAP_W'(1)) begin
                    if (w_pend) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = PLAY;
                        w_addr_nxt  = '0;
                        w_emit      = 1'b1;
                    end
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_num       <= '0;
            r_gap       <= '0;
            r_sent      <= '0;
            r_gap_cnt   <= '0;
            r_stop_pend <= 1'b0;
            busy        <= 1'b0;
            enable_in   <= 1'b0;
            in_re       <= '0;
            in_im       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_addr      <= w_addr_nxt;
            r_num       <= w_num_nxt;
            r_gap       <= w_gap_nxt;
            r_sent      <= w_sent_nxt;
            r_gap_cnt   <= w_gap_cnt_nxt;
            r_stop_pend <= w_stop_pend_nxt;
            busy        <= (w_state_nxt != IDLE);
            enable_in   <= w_emit;
            in_re       <= w_emit ? w_rd.re : '0;
            in_im       <= w_emit ? w_rd.im : '0;
        end
    end

    fft_out_tracker #(
        .N(N)
    ) u_tracker (
        .clk          (clk),
        .rst          (rst),
        .i_enable_out (enable_out),
        .o_bin        (out_bin),
        .o_frame_done (out_frame_done),
        .o_frame_err  (out_frame_err),
        .o_frames     (out_frames)
    );

endmodule

// File: tb/tb_fft_frame_streamer.sv
// Self-checking bench for fft_frame_streamer: table of streaming runs
// against a sample scoreboard, plus tracker and reset sequences.
`timescale 1ns/1ps
module tb_fft_frame_streamer;

    localparam int N  = 64;
    localparam int W  = 8;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic          start;
    logic          stop;
    logic [7:0]    num_frames;
    logic [7:0]    gap;
    logic          busy;
    logic          enable_in;
    logic [W-1:0]  in_re;
    logic [W-1:0]  in_im;
    logic          enable_out;
    logic [AW-1:0] out_bin;
    logic          out_frame_done;
    logic          out_frame_err;
    logic [15:0]   out_frames;

    always #5 clk = ~clk;

    fft_frame_streamer #(
        .N(N), .WIDTH(W), .FRAME_CNT_W(8), .GAP_W(8)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .stop(stop),
        .num_frames(num_frames), .gap(gap), .busy(busy),
        .enable_in(enable_in), .in_re(in_re), .in_im(in_im),
        .enable_out(enable_out), .out_bin(out_bin),
        .out_frame_done(out_frame_done), .out_frame_err(out_frame_err),
        .out_frames(out_frames)
    );

    int checks   = 0;
    int failures = 0;

    logic [15:0] mem [N];
    logic [15:0] exp_q [$];

    typedef struct {
        int nf;
        int gp;
        int stop_at;
        int wr_at;
        int start_at;
        int exp_frames;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_frames(input int n);
        for (int f = 0; f < n; f++)
            for (int k = 0; k < N; k++)
                exp_q.push_back(mem[k]);
    endtask

    task automatic run(input vec_t v);
        int run_len  = 0;
        int low_len  = 0;
        int frames   = 0;
        bit done     = 1'b0;
        logic [15:0] e;
        num_frames = 8'(v.nf);
        gap        = 8'(v.gp);
        start      = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            if (enable_in) begin
                if (low_len > 0) begin
                    chk("gap_len", low_len, v.gp);
                    low_len = 0;
                end
                run_len++;
                chk("busy_en", busy, 1);
                chk("sb_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("sample", {in_re, in_im}, e);
                end
            end else begin
                chk("idle_zero", {in_re, in_im}, 0);
                if (run_len > 0) begin
                    if (v.gp > 0) chk("burst_len", run_len, N);
                    else          chk("burst_mod", run_len % N, 0);
                    frames += run_len / N;
                    run_len = 0;
                end
                if (busy) low_len++;
                else      done = 1'b1;
            end
            stop    = (cyc == v.stop_at);
            start   = (cyc == v.start_at);
            wr_en   = (cyc == v.wr_at);
            wr_addr = 6'd10;
            wr_data = 16'hA55A;
            if (!done) tick();
        end
        chk("run_done", done, 1);
        chk("frames", frames, v.exp_frames);
        chk("sb_empty", exp_q.size(), 0);
        stop  = 1'b0;
        start = 1'b0;
        wr_en = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1, 0, -1, -1, -1, 1};
        vecs[1] = '{3, 5, -1, -1, -1, 3};
        vecs[2] = '{0, 0, 100, -1, -1, 2};
        vecs[3] = '{2, 0, -1, 9, -1, 2};
        vecs[4] = '{2, 1, -1, -1, 20, 2};
        vecs[5] = '{0, 3, 30, -1, -1, 1};

        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; stop = 1'b0; num_frames = '0; gap = '0;
        enable_out = 1'b0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_en", enable_in, 0);
        chk("rst_re", in_re, 0);
        chk("rst_im", in_im, 0);
        chk("rst_bin", out_bin, 0);
        chk("rst_done", out_frame_done, 0);
        chk("rst_err", out_frame_err, 0);
        chk("rst_frames", out_frames, 0);
        rst = 1'b0;

        for (int k = 0; k < N; k++) begin
            mem[k]  = {8'(k), 8'(0 - k)};
            wr_en   = 1'b1;
            wr_addr = 6'(k);
            wr_data = mem[k];
            tick();
        end
        wr_en = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].wr_at >= 0) begin
                push_frames(1);
                mem[10] = 16'hA55A;
                push_frames(vecs[i].exp_frames - 1);
            end else begin
                push_frames(vecs[i].exp_frames);
            end
            run(vecs[i]);
            tick();
        end

        // output tracker: two complete frames, then a truncated one
        for (int k = 0; k < 2 * N; k++) begin
            enable_out = 1'b1;
            chk("bin", out_bin, k % N);
            chk("done_pulse", out_frame_done, k == N);
            chk("frames_mid", out_frames, (k >= N) ? 1 : 0);
            chk("no_err", out_frame_err, 0);
            tick();
        end
        enable_out = 1'b0;
        chk("done_last", out_frame_done, 1);
        chk("frames_two", out_frames, 2);
        chk("bin_wrap", out_bin, 0);
        tick();
        chk("err_clean", out_frame_err, 0);
        for (int k = 0; k < 20; k++) begin
            enable_out = 1'b1;
            chk("bin_part", out_bin, k);
            tick();
        end
        enable_out = 1'b0;
        chk("bin_20", out_bin, 20);
        chk("err_early", out_frame_err, 0);
        tick();
        chk("err_pulse", out_frame_err, 1);
        chk("bin_clr", out_bin, 0);
        chk("frames_keep", out_frames, 2);
        tick();
        chk("err_once", out_frame_err, 0);

        // reset in the middle of a frame, then replay from sample 0
        num_frames = 8'd1;
        gap        = 8'd0;
        start      = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c <= 30; c++) begin
            chk("pre_rst_en", enable_in, 1);
            chk("pre_rst_smp", {in_re, in_im}, mem[c]);
            if (c < 30) tick();
        end
        rst = 1'b1;
        tick();
        chk("mid_rst_en", enable_in, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_data", {in_re, in_im}, 0);
        chk("mid_rst_err", out_frame_err, 0);
        chk("mid_rst_frames", out_frames, 0);
        rst = 1'b0;
        tick();
        chk("post_rst_idle", enable_in, 0);
        push_frames(1);
        run(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
